// File: rtl/set_job_scheduler_if.sv
// set_job_scheduler_if: signal bundle between the SET job scheduler and its environment.
//
// Groups three channels:
//   req0_* / req1_*  job request channels (valid/ready, central, radius, mode)
//   ctl_*            engine issue channel (en pulse, job fields) and engine result (busy, valid, cand)
//   rsp_*            response channel back to the requesters (valid/ready, id, cand, err)
//
// Modports:
//   master  environment side: requesters, engine model and response consumer
//   slave   scheduler side
interface set_job_scheduler_if #(
    parameter int unsigned CNT_W = 7
);
    logic             req0_valid;
    logic             req0_ready;
    logic [23:0]      req0_central;
    logic [11:0]      req0_radius;
    logic [1:0]       req0_mode;

    logic             req1_valid;
    logic             req1_ready;
    logic [23:0]      req1_central;
    logic [11:0]      req1_radius;
    logic [1:0]       req1_mode;

    logic             ctl_en;
    logic [23:0]      ctl_central;
    logic [11:0]      ctl_radius;
    logic [1:0]       ctl_mode;
    logic             ctl_busy;
    logic             ctl_valid;
    logic [CNT_W-1:0] ctl_cand;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [CNT_W-1:0] rsp_cand;
    logic             rsp_err;

    modport master (
        output req0_valid, req0_central, req0_radius, req0_mode,
        input  req0_ready,
        output req1_valid, req1_central, req1_radius, req1_mode,
        input  req1_ready,
        input  ctl_en, ctl_central, ctl_radius, ctl_mode,
        output ctl_busy, ctl_valid, ctl_cand,
        input  rsp_valid, rsp_id, rsp_cand, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_central, req0_radius, req0_mode,
        output req0_ready,
        input  req1_valid, req1_central, req1_radius, req1_mode,
        output req1_ready,
        output ctl_en, ctl_central, ctl_radius, ctl_mode,
        input  ctl_busy, ctl_valid, ctl_cand,
        output rsp_valid, rsp_id, rsp_cand, rsp_err,
        input  rsp_ready
    );
endinterface

// File: rtl/set_job_scheduler.sv
// set_job_scheduler: front-end scheduler for the three-circle SET evaluation engine.
//
// Arbitrates round-robin between two requesters, issues one job at a time to the engine
// (ctl_en pulse plus registered central/radius/mode), waits for the engine's ctl_valid pulse
// and returns the candidate count to the originating requester on the rsp channel.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   set_job_scheduler_if.slave (req0_*, req1_*, ctl_*, rsp_*)
//
// Optional feature: define SET_SCHED_TIMEOUT_EN to add a watchdog on the WAIT state. After
// TO_CYCLES cycles in WAIT without ctl_valid a response with rsp_err=1 and rsp_cand=0 is
// returned. Without the macro WAIT is unbounded and rsp_err is tied low.
module set_job_scheduler #(
    parameter int unsigned CNT_W     = 7,
    parameter int unsigned TO_CYCLES = 100,
    parameter int unsigned TO_W      = 8
) (
    input logic             clk,
    input logic             rst,
    set_job_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e state;
    logic   rr_ptr;   // index of the last granted requester
    logic   job_id;   // index of the job currently in flight
    logic   grant;
    logic   accept;

    // On contention the requester that did not win last time gets the grant.
    always_comb begin
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~rr_ptr;
        end else begin
            grant = bus.req1_valid;
        end
    end

    assign bus.req0_ready = (state == StIdle) && !bus.ctl_busy && !grant;
    assign bus.req1_ready = (state == StIdle) && !bus.ctl_busy && grant;
    assign accept = (bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready);

`ifdef SET_SCHED_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    logic            to_hit;

    // Fires on the WAIT edge where the count would reach TO_CYCLES.
    assign to_hit = (to_cnt == TO_W'(TO_CYCLES - 1));
`else
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= StIdle;
            rr_ptr          <= 1'b1;
            job_id          <= 1'b0;
            bus.ctl_en      <= 1'b0;
            bus.ctl_central <= '0;
            bus.ctl_radius  <= '0;
            bus.ctl_mode    <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_id      <= 1'b0;
            bus.rsp_cand    <= '0;
`ifdef SET_SCHED_TIMEOUT_EN
            bus.rsp_err     <= 1'b0;
            to_cnt          <= '0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (accept) begin
                        if (grant) begin
                            bus.ctl_central <= bus.req1_central;
                            bus.ctl_radius  <= bus.req1_radius;
                            bus.ctl_mode    <= bus.req1_mode;
                        end else begin
                            bus.ctl_central <= bus.req0_central;
                            bus.ctl_radius  <= bus.req0_radius;
                            bus.ctl_mode    <= bus.req0_mode;
                        end
                        job_id     <= grant;
                        rr_ptr     <= grant;
                        bus.ctl_en <= 1'b1;
                        state      <= StIssue;
`ifdef SET_SCHED_TIMEOUT_EN
                        to_cnt     <= '0;
`endif
                    end
                end

                // ctl_valid is deliberately not looked at while the start pulse is out.
                StIssue: begin
                    bus.ctl_en <= 1'b0;
                    state      <= StWait;
                end

                StWait: begin
                    if (bus.ctl_valid) begin
                        bus.rsp_cand  <= bus.ctl_cand;
                        bus.rsp_id    <= job_id;
                        bus.rsp_valid <= 1'b1;
                        state         <= StResp;
`ifdef SET_SCHED_TIMEOUT_EN
                        bus.rsp_err   <= 1'b0;
                    end else if (to_hit) begin
                        bus.rsp_cand  <= '0;
                        bus.rsp_id    <= job_id;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_valid <= 1'b1;
                        state         <= StResp;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end

                StResp: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= StIdle;
                    end
                end

                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_set_job_scheduler.sv
// tb_set_job_scheduler: self-checking bench for set_job_scheduler.
//
// An engine stub answers each ctl_en after a programmable delay. A negedge monitor models the
// arbiter, pushes the expected response of every accepted job into a scoreboard queue and pops
// and compares it when the response handshake happens.
`timescale 1ns/1ps
module tb_set_job_scheduler;

    localparam int unsigned CNT_W     = 7;
    localparam int unsigned TO_CYCLES = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    set_job_scheduler_if #(.CNT_W(CNT_W)) bus ();

    set_job_scheduler #(
        .CNT_W     (CNT_W),
        .TO_CYCLES (TO_CYCLES),
        .TO_W      (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Candidate count the engine stub reports for a given job.
    function automatic logic [6:0] cand_of(input logic [23:0] c, input logic [11:0] r,
                                           input logic [1:0] m);
        return c[6:0] ^ c[22:16] ^ {r[10:8], r[3:0]} ^ {5'b0, m};
    endfunction

    // ---------------- engine stub ----------------
    int         eng_delay     = 5;
    bit         eng_mute      = 1'b0;
    bit         eng_force     = 1'b0;
    logic [6:0] eng_force_val = '0;

    initial begin
        bus.ctl_valid = 1'b0;
        bus.ctl_cand  = '0;
        forever begin
            @(negedge clk);
            if (!rst && bus.ctl_en && !eng_mute) begin
                repeat (eng_delay) @(negedge clk);
                bus.ctl_cand  = eng_force ? eng_force_val
                                          : cand_of(bus.ctl_central, bus.ctl_radius, bus.ctl_mode);
                bus.ctl_valid = 1'b1;
                @(negedge clk);
                bus.ctl_valid = 1'b0;
                bus.ctl_cand  = '0;
                check_eq("rsp_latency", {31'b0, bus.rsp_valid}, 32'd1);
            end
        end
    end

    // ---------------- monitor + scoreboard ----------------
    typedef logic [8:0] exp_t;  // {err, id, cand}
    exp_t        sb[$];
    int          grant_log[$];
    bit          in_flight = 1'b0;
    bit          rr_model  = 1'b1;
    bit          acc_prev  = 1'b0;
    bit          last_hold = 1'b0;
    int          n_acc     = 0;
    int          n_rsp     = 0;
    logic [23:0] exp_c;
    logic [11:0] exp_r;
    logic [1:0]  exp_m;
    exp_t        last_rsp;
    exp_t        m_e;
    logic        m_eg;
    logic        m_a0;
    logic        m_a1;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            in_flight = 1'b0;
            rr_model  = 1'b1;
            acc_prev  = 1'b0;
            last_hold = 1'b0;
        end else begin
            check_eq("ctl_en", {31'b0, bus.ctl_en}, {31'b0, acc_prev});
            if (in_flight) begin
                check_eq("ctl_central", {8'b0, bus.ctl_central}, {8'b0, exp_c});
                check_eq("ctl_radius", {20'b0, bus.ctl_radius}, {20'b0, exp_r});
                check_eq("ctl_mode", {30'b0, bus.ctl_mode}, {30'b0, exp_m});
            end

            m_eg = (bus.req0_valid && bus.req1_valid) ? ~rr_model : bus.req1_valid;
            if (bus.req0_valid)
                check_eq("req0_ready", {31'b0, bus.req0_ready},
                         {31'b0, !in_flight && !bus.ctl_busy && !m_eg});
            if (bus.req1_valid)
                check_eq("req1_ready", {31'b0, bus.req1_ready},
                         {31'b0, !in_flight && !bus.ctl_busy && m_eg});
            if (bus.req0_valid && bus.req1_valid)
                check_eq("one_ready", {31'b0, bus.req0_ready & bus.req1_ready}, 32'd0);

            m_a0 = bus.req0_valid && bus.req0_ready;
            m_a1 = bus.req1_valid && bus.req1_ready;

            // Response side uses in_flight as it was before this cycle's accept.
            if (bus.rsp_valid) begin
                check_eq("rsp_orphan", {31'b0, in_flight}, 32'd1);
                m_e = {bus.rsp_err, bus.rsp_id, bus.rsp_cand};
                if (last_hold) check_eq("rsp_stable", {23'b0, m_e}, {23'b0, last_rsp});
                last_rsp = m_e;
                if (bus.rsp_ready) begin
                    if (sb.size() == 0) begin
                        check_eq("sb_empty", 32'd1, 32'd0);
                    end else begin
                        m_e = sb.pop_front();
                        check_eq("rsp_id", {31'b0, bus.rsp_id}, {31'b0, m_e[7]});
                        check_eq("rsp_cand", {25'b0, bus.rsp_cand}, {25'b0, m_e[6:0]});
                        check_eq("rsp_err", {31'b0, bus.rsp_err}, {31'b0, m_e[8]});
                    end
                    in_flight = 1'b0;
                    last_hold = 1'b0;
                    n_rsp++;
                end else begin
                    last_hold = 1'b1;
                end
            end else begin
                last_hold = 1'b0;
            end

            if (m_a0 || m_a1) begin
                rr_model  = m_a1;
                in_flight = 1'b1;
                exp_c     = m_a1 ? bus.req1_central : bus.req0_central;
                exp_r     = m_a1 ? bus.req1_radius : bus.req0_radius;
                exp_m     = m_a1 ? bus.req1_mode : bus.req0_mode;
                if (eng_mute)
                    m_e = {1'b1, m_a1, 7'd0};
                else
                    m_e = {1'b0, m_a1, eng_force ? eng_force_val : cand_of(exp_c, exp_r, exp_m)};
                sb.push_back(m_e);
                grant_log.push_back(int'(m_a1));
                n_acc++;
            end
            acc_prev = m_a0 || m_a1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns #1 after the edge on which accept number 'target' happened.
    task automatic wait_acc(input int target, input int budget);
        int n = 0;
        while (n_acc < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq("acc_wait", {31'b0, n_acc >= target}, 32'd1);
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int n = 0;
        while (n_rsp < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq("rsp_wait", {31'b0, n_rsp >= target}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ctl_en"}, {31'b0, bus.ctl_en}, 32'd0);
        check_eq({tag, "_rsp_valid"}, {31'b0, bus.rsp_valid}, 32'd0);
        check_eq({tag, "_rsp_id"}, {31'b0, bus.rsp_id}, 32'd0);
        check_eq({tag, "_rsp_err"}, {31'b0, bus.rsp_err}, 32'd0);
        check_eq({tag, "_rsp_cand"}, {25'b0, bus.rsp_cand}, 32'd0);
        check_eq({tag, "_ctl_central"}, {8'b0, bus.ctl_central}, 32'd0);
        check_eq({tag, "_ctl_radius"}, {20'b0, bus.ctl_radius}, 32'd0);
        check_eq({tag, "_ctl_mode"}, {30'b0, bus.ctl_mode}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got=running expected=done");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int rr_exp[4] = '{0, 1, 0, 1};
        int n;
        int rsp_before;

        bus.req0_valid = 1'b0; bus.req0_central = '0; bus.req0_radius = '0; bus.req0_mode = '0;
        bus.req1_valid = 1'b0; bus.req1_central = '0; bus.req1_radius = '0; bus.req1_mode = '0;
        bus.ctl_busy   = 1'b0;
        bus.rsp_ready  = 1'b1;

        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Single job from req0, engine answers 17 after 24 cycles.
        eng_delay = 24; eng_force = 1'b1; eng_force_val = 7'd17;
        bus.req0_central = 24'h123456; bus.req0_radius = 12'h345; bus.req0_mode = 2'b00;
        bus.req0_valid = 1'b1;
        wait_acc(1, 20);
        bus.req0_valid = 1'b0;
        wait_rsp(1, 100);
        eng_force = 1'b0;
        eng_delay = 6;

        // Engine busy blocks the grant; ready follows busy dropping.
        bus.ctl_busy = 1'b1;
        bus.req1_central = 24'hA5C3E1; bus.req1_radius = 12'h9B2; bus.req1_mode = 2'b01;
        bus.req1_valid = 1'b1;
        repeat (5) tick();
        check_eq("busy_no_acc", n_acc, 32'd1);
        bus.ctl_busy = 1'b0;
        wait_acc(2, 2);
        bus.req1_valid = 1'b0;
        wait_rsp(2, 100);

        // Both requesters held valid: round-robin 0,1,0,1.
        bus.req0_central = 24'h0F1E2D; bus.req0_radius = 12'h7A4; bus.req0_mode = 2'b10;
        bus.req1_central = 24'hFEDCBA; bus.req1_radius = 12'h123; bus.req1_mode = 2'b11;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        wait_acc(6, 400);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        wait_rsp(6, 100);
        for (int i = 0; i < 4; i++)
            check_eq("rr_order", grant_log.size() > 2 + i ? grant_log[2 + i] : -1, rr_exp[i]);

        // Response stall: rsp_* held, no new accept until the rsp_ready edge.
        bus.rsp_ready = 1'b0;
        bus.req0_central = 24'h13579B; bus.req0_radius = 12'h2C6; bus.req0_mode = 2'b01;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        wait_acc(7, 20);
        bus.req0_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 100) begin
            tick();
            n++;
        end
        check_eq("stall_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
        repeat (10) tick();
        check_eq("stall_no_acc", n_acc, 32'd7);
        check_eq("stall_rsp_held", {31'b0, bus.rsp_valid}, 32'd1);
        bus.rsp_ready = 1'b1;
        wait_acc(8, 5);
        bus.req1_valid = 1'b0;
        wait_rsp(8, 100);

        // Reset in WAIT drops the job; next contention goes to req0.
        eng_mute = 1'b1;
        bus.req0_valid = 1'b1;
        wait_acc(9, 20);
        bus.req0_valid = 1'b0;
        repeat (5) tick();
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        rsp_before = n_rsp;
        tick();
        rst = 1'b0;
        repeat (30) tick();
        check_eq("reset_no_rsp", n_rsp, rsp_before);
        check_eq("reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        eng_mute = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        wait_acc(10, 20);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check_eq("reset_grant", grant_log.size() > 9 ? grant_log[9] : -1, 32'd0);
        wait_rsp(rsp_before + 1, 100);

        // Engine never answers.
        eng_mute = 1'b1;
        bus.req1_valid = 1'b1;
        wait_acc(11, 20);
        bus.req1_valid = 1'b0;
        @(posedge clk);  // ISSUE -> WAIT
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.rsp_valid && n < 200);
`ifdef SET_SCHED_TIMEOUT_EN
        check_eq("timeout_cycles", n, TO_CYCLES);
        wait_rsp(rsp_before + 2, 20);
`else
        check_eq("no_timeout_rsp", {31'b0, bus.rsp_valid}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
`endif
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
